// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;
  typedef enum logic {REQ_CORE, REQ_DMA} req_id_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// DMA burst address/beat counter: loads start address and length at ack,
// advances one word per beat and flags the final beat.
module burst_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [ADDR_W-1:0]  loadAddr,
  input  logic [BURST_W-1:0] loadLen,
  input  logic               step,
  output logic [ADDR_W-1:0]  beatAddr,
  output logic               lastBeat
);

  logic [ADDR_W-1:0]  addrReg;
  logic [BURST_W-1:0] countReg;

  // Start address is forced word aligned; stepping wraps silently at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addrReg  <= '0;
      countReg <= '0;
    end else if (load) begin
      addrReg  <= loadAddr & ~ADDR_W'(WORD_BYTES - 1);
      countReg <= loadLen;
    end else if (step) begin
      addrReg  <= addrReg + ADDR_W'(WORD_BYTES);
      countReg <= countReg - BURST_W'(1);
    end
  end

  assign beatAddr = addrReg;
  assign lastBeat = (countReg == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between single-beat core
// accesses and DMA word bursts of 1..MAX_BURST beats.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  localparam int BURST_W  = $clog2(MAX_BURST)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [DATA_W-1:0]  core_wdata,
  output logic               core_gnt,
  output logic [DATA_W-1:0]  core_rdata,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [BURST_W-1:0] dma_len,
  output logic               dma_ack,
  input  logic [DATA_W-1:0]  dma_wdata,
  output logic               dma_wready,
  output logic [DATA_W-1:0]  dma_rdata,
  output logic               dma_rvalid,
  output logic               dma_done,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  arb_state_t        state, stateNext;
  req_id_t           rrPtr, rrPtrNext;
  logic              burstWe, loadBurst, stepBeat, lastBeat;
  logic [ADDR_W-1:0] beatAddr;

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .BURST_W(BURST_W)
  ) addrGen (
    .clk     (clk),
    .reset   (reset),
    .load    (loadBurst),
    .loadAddr(dma_addr),
    .loadLen (dma_len),
    .step    (stepBeat),
    .beatAddr(beatAddr),
    .lastBeat(lastBeat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rrPtr   <= REQ_CORE;
      burstWe <= 1'b0;
    end else begin
      state <= stateNext;
      rrPtr <= rrPtrNext;
      if (loadBurst) burstWe <= dma_we;
    end
  end

  always_comb begin
    stateNext  = state;
    rrPtrNext  = rrPtr;
    core_gnt   = 1'b0;
    dma_ack    = 1'b0;
    dma_wready = 1'b0;
    dma_rvalid = 1'b0;
    dma_done   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    loadBurst  = 1'b0;
    stepBeat   = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req && (!dma_req || rrPtr == REQ_CORE)) begin
          core_gnt  = 1'b1;
          mem_we    = core_we;
          rrPtrNext = REQ_DMA;
        end else if (dma_req) begin
          // Ack cycle only latches operands; the port stays idle.
          dma_ack   = 1'b1;
          loadBurst = 1'b1;
          rrPtrNext = REQ_CORE;
          stateNext = BURST;
        end
      end
      BURST: begin
        mem_addr = beatAddr;
        stepBeat = 1'b1;
        if (burstWe) begin
          mem_we     = 1'b1;
          mem_wdata  = dma_wdata;
          dma_wready = 1'b1;
        end else begin
          dma_rvalid = 1'b1;
        end
        if (lastBeat) begin
          dma_done  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Handshakes and writes are suppressed for the whole time reset is held.
    if (!reset) begin
      core_gnt   = 1'b0;
      dma_ack    = 1'b0;
      dma_wready = 1'b0;
      dma_rvalid = 1'b0;
      dma_done   = 1'b0;
      mem_we     = 1'b0;
      loadBurst  = 1'b0;
      stepBeat   = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table and corner sequences,
// then randomized traffic against a schedule-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_gnt;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dma_req, dma_we, dma_ack, dma_wready, dma_rvalid, dma_done;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        memClear;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_ack(dma_ack), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory with combinational read, aliased onto 256 words.
  logic [31:0] physMem [256];
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) physMem[i] <= 32'd0;
    end else if (mem_we) begin
      physMem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = physMem[mem_addr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags = {core_gnt, dma_ack, mem_we, dma_wready, dma_rvalid, dma_done}
  task automatic chk(input string name, input logic [5:0] expFlags, input bit chkAddr,
                     input logic [31:0] expAddr);
    logic [5:0] actFlags;
    actFlags = {core_gnt, dma_ack, mem_we, dma_wready, dma_rvalid, dma_done};
    vecCount++;
    if (actFlags !== expFlags || (chkAddr && mem_addr !== expAddr)) begin
      missCount++;
      $display("FAIL %s: flags=%b addr=%h, want flags=%b addr=%h", name, actFlags, mem_addr,
               expFlags, chkAddr ? expAddr : mem_addr);
    end
  endtask

  task automatic chkData(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expGnt;
    logic [31:0] expRdata;
  } coreVec_t;
  coreVec_t vecs [6];

  // Reference model state (random phase)
  logic [31:0] modelMem [256];
  bit          corePriority;
  int          ackCyc, burstEnd;
  logic [31:0] base;
  bit          bWe;
  logic [3:0]  bLen;

  initial begin
    int stall, beats;
    bit dmaHold, inBurst;
    logic [5:0]   expF;
    logic [101:0] expV, actV;
    logic [31:0]  a;
    int k;
    bit chkA, chkW;
    int rdSel;

    vecs[0] = '{1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'h40, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h44, 32'h12345678, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h40, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h44, 32'h0,        1'b1, 32'h12345678};
    vecs[5] = '{1'b0, 32'h40, 32'h0,        1'b1, 32'hCAFEF00D};

    reset = 1'b0; memClear = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_len = 4'd0; dma_wdata = 32'h0;
    tick();
    @(negedge clk);
    chk("reset_forced_low", 6'b000000, 1'b0, 32'h0);
    tick();
    reset = 1'b1; memClear = 1'b0; core_req = 1'b0; dma_req = 1'b0;

    // Core-only accesses from the table
    for (int i = 0; i < 6; i++) begin
      core_req = 1'b1; core_we = vecs[i].we; core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
      @(negedge clk);
      chk("core_vec", {vecs[i].expGnt, 1'b0, vecs[i].we, 3'b000}, 1'b1, vecs[i].addr);
      if (!vecs[i].we) chkData("core_vec_rdata", core_rdata, vecs[i].expRdata);
      $display("core vec %0d we=%0b addr=%h wdata=%h rdata=%h", i, core_we, core_addr,
               core_wdata, core_rdata);
      tick();
    end
    core_req = 1'b0;

    // DMA write burst, 4 beats from 0x100
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_len = 4'd3;
    @(negedge clk);
    chk("dma_wr_ack", 6'b010000, 1'b0, 32'h0);
    tick();
    dma_req = 1'b0; dma_addr = 32'h3F0; dma_we = 1'b0; dma_len = 4'd9;
    for (int j = 0; j < 4; j++) begin
      dma_wdata = 32'hA0 + 32'(j);
      @(negedge clk);
      chk("dma_wr_beat", {5'b00110, j == 3}, 1'b1, 32'h100 + 32'(4 * j));
      chkData("dma_wr_wdata", mem_wdata, 32'hA0 + 32'(j));
      tick();
    end
    @(negedge clk);
    chk("dma_wr_after", 6'b000000, 1'b0, 32'h0);
    $display("dma write burst addr=00000100 len=3 complete");
    tick();

    // Both request with core priority: core first, then DMA, then core after done
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h11111111;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = 4'd1;
    @(negedge clk);
    chk("tie_core_first", 6'b101000, 1'b1, 32'h80);
    tick();
    core_we = 1'b0;
    @(negedge clk);
    chk("tie_dma_next", 6'b010000, 1'b0, 32'h0);
    tick();
    dma_req = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("tie_rd_beat", {5'b00001, j == 1}, 1'b1, 32'h100 + 32'(4 * j));
      chkData("tie_rd_data", dma_rdata, 32'hA0 + 32'(j));
      tick();
    end
    @(negedge clk);
    chk("tie_core_after_done", 6'b100000, 1'b1, 32'h80);
    chkData("tie_core_rdata", core_rdata, 32'h11111111);
    $display("tie sequence complete");
    tick();
    core_req = 1'b0;

    // Max-length read burst while the core waits
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; dma_len = 4'd15;
    stall = 0; beats = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (core_gnt) break;
      stall++;
      if (dma_rvalid) beats++;
      tick();
      if (dma_ack === 1'b0 && stall == 1) dma_req = 1'b0;
    end
    vecCount++;
    if (stall != 17 || beats != 16) begin
      missCount++;
      $display("FAIL max_burst_stall: stall=%0d beats=%0d, want stall=17 beats=16", stall, beats);
    end
    chkData("max_burst_core_rdata", core_rdata, 32'hA0);
    $display("max burst: core stalled %0d cycles, %0d read beats", stall, beats);
    tick();
    core_req = 1'b0; dma_req = 1'b0;

    // Address wrap
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hFFFFFFF8; dma_len = 4'd3;
    @(negedge clk);
    chk("wrap_ack", 6'b010000, 1'b0, 32'h0);
    tick();
    dma_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      dma_wdata = 32'hB0 + 32'(j);
      @(negedge clk);
      chk("wrap_beat", {5'b00110, j == 3}, 1'b1, 32'hFFFFFFF8 + 32'(4 * j));
      tick();
    end
    $display("wrap burst complete");

    // Reset during beat 2 of an 8-beat write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_len = 4'd7;
    @(negedge clk);
    chk("rst_mid_ack", 6'b010000, 1'b0, 32'h0);
    tick();
    dma_req = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("rst_mid_beat", 6'b001100, 1'b1, 32'h200 + 32'(4 * j));
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_forced", 6'b000000, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rst_mid_idle", 6'b000000, 1'b0, 32'h0);
      tick();
    end
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; dma_req = 1'b1;
    @(negedge clk);
    chk("rst_mid_rr_core", 6'b100000, 1'b1, 32'h40);
    $display("reset mid-burst sequence complete");
    tick();

    // Randomized traffic against the reference model
    core_req = 1'b0; dma_req = 1'b0; reset = 1'b0; memClear = 1'b1;
    tick();
    reset = 1'b1; memClear = 1'b0;
    for (int i = 0; i < 256; i++) modelMem[i] = 32'd0;
    corePriority = 1'b1; ackCyc = -10; burstEnd = -10; base = 32'd0; bWe = 1'b0; bLen = 4'd0;
    dmaHold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      core_req   = ($urandom_range(0, 2) != 0);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      core_wdata = $urandom;
      if (!dmaHold) begin
        dma_req  = ($urandom_range(0, 3) == 0);
        dma_we   = 1'($urandom_range(0, 1));
        dma_addr = $urandom;
        dma_len  = 4'($urandom_range(0, 15));
        dmaHold  = dma_req;
      end
      dma_wdata = $urandom;
      @(negedge clk);

      inBurst = (c > ackCyc) && (c <= burstEnd);
      expF = 6'b000000; a = 32'd0; chkA = 1'b0; chkW = 1'b0; rdSel = 0;
      expV = '0;
      if (inBurst) begin
        k = c - ackCyc - 1;
        a = base + 32'(4 * k);
        expF = {2'b00, bWe, bWe, !bWe, c == burstEnd};
        chkA = 1'b1; chkW = bWe; rdSel = bWe ? 0 : 2;
        expV[95:64] = a;
        expV[63:32] = bWe ? dma_wdata : 32'd0;
        expV[31:0]  = bWe ? 32'd0 : modelMem[a[9:2]];
        if (c == burstEnd)
          $display("rand c=%0d burst done base=%h len=%0d we=%0b", c, base, bLen, bWe);
      end else if (core_req && (!dma_req || corePriority)) begin
        a = core_addr;
        expF = {2'b10, core_we, 3'b000};
        chkA = 1'b1; chkW = core_we; rdSel = core_we ? 0 : 1;
        expV[95:64] = a;
        expV[63:32] = core_we ? core_wdata : 32'd0;
        expV[31:0]  = core_we ? 32'd0 : modelMem[a[9:2]];
        corePriority = 1'b0;
        $display("rand c=%0d core we=%0b addr=%h", c, core_we, core_addr);
      end else if (dma_req) begin
        expF = 6'b010000;
        ackCyc = c; burstEnd = c + int'(dma_len) + 1;
        base = {dma_addr[31:2], 2'b00}; bWe = dma_we; bLen = dma_len;
        corePriority = 1'b1; dmaHold = 1'b0;
        $display("rand c=%0d dma ack addr=%h len=%0d we=%0b", c, dma_addr, dma_len, dma_we);
      end
      expV[101:96] = expF;
      actV[101:96] = {core_gnt, dma_ack, mem_we, dma_wready, dma_rvalid, dma_done};
      actV[95:64]  = chkA ? mem_addr : 32'd0;
      actV[63:32]  = chkW ? mem_wdata : 32'd0;
      actV[31:0]   = (rdSel == 1) ? core_rdata : (rdSel == 2) ? dma_rdata : 32'd0;
      vecCount++;
      if (actV !== expV) begin
        missCount++;
        $display("FAIL rand_c%0d: got flags=%b addr=%h wd=%h rd=%h, want flags=%b addr=%h wd=%h rd=%h",
                 c, actV[101:96], actV[95:64], actV[63:32], actV[31:0],
                 expV[101:96], expV[95:64], expV[63:32], expV[31:0]);
      end
      if (expF[3]) modelMem[a[9:2]] = expV[63:32];
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
